// File: rtl/writeback_reorder_buffer.sv
// rtl/writeback_reorder_buffer.sv - in-order writeback commit buffer
// Results complete out of order by tag and retire in allocation order, one per cycle.
module writeback_reorder_buffer #(
  parameter int WORD_WIDTH           = 32,
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int NUM_ENTRIES          = 8,
  parameter int TAG_WIDTH            = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            alloc_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] alloc_dest_idx,
  output logic                            alloc_ready,
  output logic [TAG_WIDTH-1:0]            alloc_tag,
  input  logic                            complete_valid,
  input  logic [TAG_WIDTH-1:0]            complete_tag,
  input  logic [WORD_WIDTH-1:0]           complete_data,
  input  logic                            flush,
  output logic                            wb_write_enable,
  output logic [REGISTER_INDEX_WIDTH-1:0] wb_write_idx,
  output logic [WORD_WIDTH-1:0]           wb_write_data,
  output logic [TAG_WIDTH:0]              count,
  output logic                            empty,
  output logic                            full
);

  localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH+1)'(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0]          valid_q, valid_d;
  logic [NUM_ENTRIES-1:0]          done_q, done_d;
  logic [REGISTER_INDEX_WIDTH-1:0] dest_q [NUM_ENTRIES];
  logic [WORD_WIDTH-1:0]           data_q [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]            head_q, head_d;
  logic [TAG_WIDTH-1:0]            tail_q, tail_d;
  logic [TAG_WIDTH:0]              count_q, count_d;
  logic                            wb_we_q;
  logic [REGISTER_INDEX_WIDTH-1:0] wb_idx_q;
  logic [WORD_WIDTH-1:0]           wb_data_q;

  logic do_alloc, do_complete, do_commit;

  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;

  assign do_alloc    = alloc_valid && !full;
  assign do_complete = complete_valid && valid_q[complete_tag] && !done_q[complete_tag];
  // Commit decision uses only registered state, so a completion lands one cycle before retiring.
  assign do_commit   = valid_q[head_q] && done_q[head_q];

  assign wb_write_enable = wb_we_q;
  assign wb_write_idx    = wb_idx_q;
  assign wb_write_data   = wb_data_q;

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (do_commit) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (do_complete) begin
      done_d[complete_tag] = 1'b1;
    end
    if (do_alloc) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
    end
    head_d  = do_commit ? head_q + TAG_WIDTH'(1) : head_q;
    tail_d  = do_alloc ? tail_q + TAG_WIDTH'(1) : tail_q;
    count_d = count_q + (TAG_WIDTH+1)'(do_alloc) - (TAG_WIDTH+1)'(do_commit);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wb_we_q <= 1'b0;
      if (reset) begin
        wb_idx_q  <= '0;
        wb_data_q <= '0;
      end
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Register 0 is hardwired zero: the entry retires but never writes.
      wb_we_q <= do_commit && (dest_q[head_q] != '0);
      if (do_commit) begin
        wb_idx_q  <= dest_q[head_q];
        wb_data_q <= data_q[head_q];
      end
      if (do_complete) begin
        data_q[complete_tag] <= complete_data;
      end
      if (do_alloc) begin
        dest_q[tail_q] <= alloc_dest_idx;
      end
    end
  end

endmodule

// File: tb/tb_writeback_reorder_buffer.sv
// tb/tb_writeback_reorder_buffer.sv - self-checking bench for writeback_reorder_buffer
module tb_writeback_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_dest_idx = '0;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        complete_valid = 1'b0;
  logic [2:0]  complete_tag = '0;
  logic [31:0] complete_data = '0;
  logic        flush = 1'b0;
  logic        wb_write_enable;
  logic [4:0]  wb_write_idx;
  logic [31:0] wb_write_data;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  writeback_reorder_buffer #(
    .WORD_WIDTH(32), .REGISTER_INDEX_WIDTH(5), .NUM_ENTRIES(8), .TAG_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_dest_idx(alloc_dest_idx),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .complete_valid(complete_valid), .complete_tag(complete_tag), .complete_data(complete_data),
    .flush(flush),
    .wb_write_enable(wb_write_enable), .wb_write_idx(wb_write_idx), .wb_write_data(wb_write_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t wlog[$];

  typedef struct {
    logic        rst, av;
    logic [4:0]  ad;
    logic        cv;
    logic [2:0]  ct;
    logic [31:0] cd;
    logic        fl;
    logic        ewe;
    logic [4:0]  eidx;
    logic [31:0] edata;
    logic [3:0]  ecnt;
    logic [2:0]  etag;
    logic        chkwd;
  } vec_t;
  vec_t vq[$];

  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  dest;
    bit          done;
    logic [31:0] data;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (wb_write_enable === 1'b1) wlog.push_back('{wb_write_idx, wb_write_data, cyc});
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; complete_valid = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic rst, input logic av, input logic [4:0] ad,
                         input logic cv, input logic [2:0] ct, input logic [31:0] cd,
                         input logic fl, input logic ewe, input logic [4:0] eidx,
                         input logic [31:0] edata, input logic [3:0] ecnt,
                         input logic [2:0] etag, input logic chkwd);
    vec_t v;
    v = '{rst, av, ad, cv, ct, cd, fl, ewe, eidx, edata, ecnt, etag, chkwd};
    vq.push_back(v);
  endtask

  initial begin
    // rst av ad cv ct cd fl | we idx data cnt tag chkwd
    add_vec(1, 0, 0,  0, 0, 0,            0, 0, 0,  0,            0, 0, 1);
    add_vec(1, 0, 0,  0, 0, 0,            0, 0, 0,  0,            0, 0, 1);
    add_vec(0, 1, 5,  0, 0, 0,            0, 0, 0,  0,            1, 1, 0);
    add_vec(0, 0, 0,  1, 0, 32'hDEADBEEF, 0, 0, 0,  0,            1, 1, 0);
    add_vec(0, 0, 0,  0, 0, 0,            0, 1, 5,  32'hDEADBEEF, 0, 1, 1);
    add_vec(0, 0, 0,  0, 0, 0,            0, 0, 5,  32'hDEADBEEF, 0, 1, 1);
    add_vec(0, 1, 0,  0, 0, 0,            0, 0, 0,  0,            1, 2, 0);
    add_vec(0, 0, 0,  1, 1, 32'hFFFFFFFF, 0, 0, 0,  0,            1, 2, 0);
    add_vec(0, 0, 0,  0, 0, 0,            0, 0, 0,  0,            0, 2, 0);
    add_vec(0, 0, 0,  0, 0, 0,            0, 0, 0,  0,            0, 2, 0);
    add_vec(0, 1, 7,  0, 0, 0,            0, 0, 0,  0,            1, 3, 0);
    add_vec(0, 1, 8,  0, 0, 0,            0, 0, 0,  0,            2, 4, 0);
    add_vec(0, 1, 9,  0, 0, 0,            0, 0, 0,  0,            3, 5, 0);
    add_vec(0, 0, 0,  1, 3, 32'hAA,       0, 0, 0,  0,            3, 5, 0);
    add_vec(0, 1, 10, 0, 0, 0,            1, 0, 0,  0,            0, 0, 0);
    add_vec(0, 0, 0,  1, 0, 32'hBB,       0, 0, 0,  0,            0, 0, 0);
    add_vec(0, 0, 0,  0, 0, 0,            0, 0, 0,  0,            0, 0, 0);
    add_vec(0, 1, 11, 0, 0, 0,            0, 0, 0,  0,            1, 1, 0);
    add_vec(0, 0, 0,  1, 0, 32'h1234,     0, 0, 0,  0,            1, 1, 0);
    add_vec(0, 0, 0,  0, 0, 0,            0, 1, 11, 32'h1234,     0, 1, 1);
    add_vec(0, 0, 0,  0, 0, 0,            0, 0, 0,  0,            0, 1, 0);

    #1;
    foreach (vq[i]) begin
      reset = vq[i].rst; alloc_valid = vq[i].av; alloc_dest_idx = vq[i].ad;
      complete_valid = vq[i].cv; complete_tag = vq[i].ct; complete_data = vq[i].cd;
      flush = vq[i].fl;
      step();
      chk($sformatf("vec%0d_we", i), wb_write_enable, vq[i].ewe);
      chk($sformatf("vec%0d_count", i), count, vq[i].ecnt);
      chk($sformatf("vec%0d_empty", i), empty, vq[i].ecnt == 0);
      chk($sformatf("vec%0d_full", i), full, vq[i].ecnt == 8);
      chk($sformatf("vec%0d_ready", i), alloc_ready, vq[i].ecnt != 8);
      chk($sformatf("vec%0d_tag", i), alloc_tag, vq[i].etag);
      if (vq[i].chkwd) begin
        chk($sformatf("vec%0d_idx", i), wb_write_idx, vq[i].eidx);
        chk($sformatf("vec%0d_data", i), wb_write_data, vq[i].edata);
      end
    end
    idle_inputs();

    // Out-of-order completion, in-order retirement
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_dest_idx = 5'(i + 1);
      step();
    end
    alloc_valid = 1'b0;
    wlog.delete();
    complete_valid = 1'b1;
    complete_tag = 3'd2; complete_data = 32'h33; step();
    complete_tag = 3'd0; complete_data = 32'h11; step();
    complete_tag = 3'd1; complete_data = 32'h22; step();
    complete_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("ooo_write_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("ooo_idx0", wlog[0].idx, 1);  chk("ooo_data0", wlog[0].data, 32'h11);
      chk("ooo_idx1", wlog[1].idx, 2);  chk("ooo_data1", wlog[1].data, 32'h22);
      chk("ooo_idx2", wlog[2].idx, 3);  chk("ooo_data2", wlog[2].data, 32'h33);
      chk("ooo_back_to_back", wlog[2].cyc - wlog[1].cyc, 1);
    end
    chk("ooo_empty", empty, 1);

    // Fill, overflow attempt, drain, wrap
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_dest_idx = 5'(i + 1);
      step();
    end
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);
    chk("fill_ready", alloc_ready, 0);
    alloc_dest_idx = 5'd31;
    step();
    alloc_valid = 1'b0;
    chk("overflow_count", count, 8);
    chk("overflow_tag", alloc_tag, 0);
    wlog.delete();
    for (int i = 0; i < 8; i++) begin
      complete_valid = 1'b1; complete_tag = 3'(i); complete_data = 32'h100 + i;
      step();
    end
    complete_valid = 1'b0;
    for (int n = 0; n < 20 && !empty; n++) step();
    chk("drain_empty", empty, 1);
    chk("drain_writes", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      chk($sformatf("drain_idx%0d", i), wlog[i].idx, i + 1);
      chk($sformatf("drain_data%0d", i), wlog[i].data, 32'h100 + i);
    end
    chk("wrap_tag", alloc_tag, 0);
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_dest_idx = 5'(i + 9);
      step();
    end
    alloc_valid = 1'b0;
    chk("wrap_count", count, 8);
    chk("wrap_full", full, 1);

    // Randomized traffic against a queue-based reference model
    reset_dut();
    begin
      ent_t q[$];
      int          mtail;
      bit          exp_we, commit;
      logic [4:0]  exp_idx;
      logic [31:0] exp_data;
      ent_t        c;
      mtail = 0;
      for (int n = 0; n < 1500; n++) begin
        alloc_valid    = ($urandom % 2) == 0;
        alloc_dest_idx = 5'($urandom);
        complete_valid = ($urandom % 5) < 3;
        if (q.size() > 0 && ($urandom % 4) != 0)
          complete_tag = q[$urandom % q.size()].tag;
        else
          complete_tag = 3'($urandom_range(0, 7));
        complete_data = $urandom;
        flush = ($urandom % 50) == 0;

        commit = q.size() > 0 && q[0].done;
        c = commit ? q[0] : '{0, 0, 0, 0};
        exp_we = 0; exp_idx = 0; exp_data = 0;
        if (flush) begin
          q.delete();
          mtail = 0;
        end else begin
          if (complete_valid)
            foreach (q[k])
              if (q[k].tag == complete_tag && !q[k].done) begin
                q[k].done = 1; q[k].data = complete_data;
              end
          if (alloc_valid && q.size() < 8) begin
            q.push_back('{3'(mtail), alloc_dest_idx, 0, 0});
            mtail = (mtail + 1) % 8;
          end
          if (commit) begin
            void'(q.pop_front());
            exp_we = c.dest != 0; exp_idx = c.dest; exp_data = c.data;
          end
        end
        step();
        chk("rnd_we", wb_write_enable, exp_we);
        if (exp_we) begin
          chk("rnd_idx", wb_write_idx, exp_idx);
          chk("rnd_data", wb_write_data, exp_data);
        end
        chk("rnd_count", count, q.size());
        chk("rnd_empty", empty, q.size() == 0);
        chk("rnd_full", full, q.size() == 8);
        chk("rnd_ready", alloc_ready, q.size() != 8);
        chk("rnd_tag", alloc_tag, mtail);
      end
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
